// File: rtl/regfile_sweeper.sv
// regfile_sweeper: sequences FILL / DUMP / SUM passes over a 16x8 register file port.
module regfile_sweeper #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int SW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] seed,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] sum
);
  typedef enum logic [2:0] {IDLE, FILL, DUMP, SUM, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          last;
  assign last = &idx_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seed_d  = seed_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (start && op != 2'b11) begin
        state_d = op == 2'b00 ? FILL : op == 2'b01 ? DUMP : SUM;
        idx_d   = '0;
        seed_d  = seed;
      end
      FILL: begin
        idx_d   = idx_q + 1'b1;
        state_d = last ? DONE : FILL;
      end
      DUMP: if (out_ready) begin
        idx_d   = idx_q + 1'b1;
        state_d = last ? DONE : DUMP;
      end
      SUM: begin
        // idx 0 marks the first SUM cycle, so the accumulator restarts there
        sum_d   = (idx_q == '0 ? '0 : sum_q) + SW'(mem_dout);
        idx_d   = idx_q + 1'b1;
        state_d = last ? DONE : SUM;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      seed_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seed_q  <= seed_d;
      sum_q   <= sum_d;
    end
  end
  assign mem_we    = state_q == FILL;
  assign mem_addr  = (state_q == FILL || state_q == DUMP || state_q == SUM) ? idx_q : '0;
  assign mem_din   = state_q == FILL ? seed_q + DW'(idx_q) : '0;
  assign out_valid = state_q == DUMP;
  assign out_data  = state_q == DUMP ? mem_dout : '0;
  assign out_addr  = state_q == DUMP ? idx_q : '0;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign sum       = sum_q;
endmodule

// File: tb/tb_regfile_sweeper.sv
// tb_regfile_sweeper: directed checks of regfile_sweeper against a behavioural 16x8 register file.
module tb_regfile_sweeper;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0, preload = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  seed = 8'h00;
  logic        mem_we, out_valid, busy, done;
  logic [3:0]  mem_addr, out_addr;
  logic [7:0]  mem_din, mem_dout, out_data;
  logic [11:0] sum;
  logic [7:0]  mem [16];
  logic [7:0]  exp_mem [16];
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (preload) for (int k = 0; k < 16; k++) mem[k] <= 8'hFF;
    else if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  regfile_sweeper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .seed(seed),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done), .sum(sum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] o, input logic [7:0] s);
    op = o; seed = s; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_fill(input logic [7:0] s);
    go(2'b00, s);
    for (int i = 0; i < 16; i++) begin
      chk("fill_we", 32'(mem_we), 1);
      chk("fill_addr", 32'(mem_addr), i);
      chk("fill_din", 32'(mem_din), 32'(8'(s + i)));
      chk("fill_done", 32'(done), 0);
      exp_mem[i] = 8'(s + i);
      if (i == 3) begin op = 2'b01; start = 1'b1; end else start = 1'b0;
      step();
    end
    start = 1'b0;
    chk("fill_end_done", 32'(done), 1);
    chk("fill_end_busy", 32'(busy), 1);
    chk("fill_end_we", 32'(mem_we), 0);
    step();
    chk("fill_idle_done", 32'(done), 0);
    chk("fill_idle_busy", 32'(busy), 0);
  endtask

  task automatic do_dump(input logic [3:0] pat);
    int beats = 0, cyc = 0;
    go(2'b01, 8'h00);
    while (done !== 1'b1 && cyc < 200) begin
      out_ready = pat[cyc % 4];
      chk("dump_valid", 32'(out_valid), 1);
      chk("dump_we", 32'(mem_we), 0);
      chk("dump_addr", 32'(out_addr), 32'(beats));
      chk("dump_data", 32'(out_data), 32'(exp_mem[beats[3:0]]));
      if (out_ready) beats++;
      cyc++;
      step();
    end
    out_ready = 1'b0;
    chk("dump_done", 32'(done), 1);
    chk("dump_beats", 32'(beats), 16);
    chk("dump_end_valid", 32'(out_valid), 0);
    step();
    chk("dump_idle_done", 32'(done), 0);
  endtask

  task automatic do_sum(input logic [11:0] e);
    go(2'b10, 8'h00);
    for (int i = 0; i < 16; i++) begin
      chk("sum_we", 32'(mem_we), 0);
      chk("sum_addr", 32'(mem_addr), i);
      chk("sum_done", 32'(done), 0);
      step();
    end
    chk("sum_end_done", 32'(done), 1);
    chk("sum_value", 32'(sum), 32'(e));
    step();
    chk("sum_held", 32'(sum), 32'(e));
    chk("sum_idle_busy", 32'(busy), 0);
  endtask

  initial begin
    preload = 1'b1;
    step();
    step();
    preload = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_din", 32'(mem_din), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);
    // all entries 0xFF: largest possible checksum, 16*255
    do_sum(12'hFF0);
    do_fill(8'hF8);
    do_dump(4'b1111);
    do_sum(12'h7F8);
    do_fill(8'hFF);
    do_sum(12'h168);
    do_dump(4'b1001);
    chk("sum_kept_after_fill_dump", 32'(sum), 32'h168);
    go(2'b11, 8'h55);
    chk("rsv_busy", 32'(busy), 0);
    chk("rsv_we", 32'(mem_we), 0);
    chk("rsv_done", 32'(done), 0);
    step();
    chk("rsv_busy2", 32'(busy), 0);
    chk("rsv_done2", 32'(done), 0);
    go(2'b00, 8'h10);
    for (int i = 0; i < 4; i++) step();
    chk("mid_addr", 32'(mem_addr), 4);
    chk("mid_we", 32'(mem_we), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_we", 32'(mem_we), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_sum", 32'(sum), 0);
    step();
    chk("mid_rst_done2", 32'(done), 0);
    chk("mid_rst_we2", 32'(mem_we), 0);
    for (int i = 0; i < 5; i++) exp_mem[i] = 8'(8'h10 + i);
    do_dump(4'b1111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
